// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: data memory for the load/store path, with a valid/ready
// request/response handshake, configurable access latency, base address and
// depth, and error reporting. Only one access can be outstanding at a time.
// All state changes on the falling edge of clock; clear_n is an asynchronous
// active-low reset.
// Build option: define DMEM_SUBWORD_EN to support byte and halfword accesses.
// Without it only word accesses are legal, and req_unsigned has no effect.
module data_memory_ctrl #(
   parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 1
) (
   input  logic        clock,
   input  logic        clear_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  count;
   logic [31:0] mem [DEPTH_WORDS];

   logic        lat_write;
   logic [31:0] lat_addr;
   logic [1:0]  lat_size;
   logic [31:0] lat_wdata;

   logic        execute;
   logic        a_write;
   logic [31:0] a_addr;
   logic [1:0]  a_size;
   logic [31:0] a_wdata;
   logic [31:0] offset;
   logic [IDX_W-1:0] word_idx;
   logic [31:0] rd_word;
   logic        size_bad;
   logic        acc_error;
   logic [31:0] wr_mask;
   logic [31:0] wr_data;
   logic [31:0] ld_data;

`ifdef DMEM_SUBWORD_EN
   logic        lat_unsigned;
   logic        a_unsigned;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
`else
   logic        unused_unsigned;
   assign unused_unsigned = req_unsigned;
`endif

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);

   // Pick the access being executed: with a single-edge latency the access
   // runs on the accept edge itself, so it must come straight from req_*.
   always_comb begin
      execute = ((state == S_IDLE) && req_valid && (LATENCY == 1)) ||
                ((state == S_WAIT) && (count == 4'd1));
      if (state == S_IDLE) begin
         a_write = req_write;
         a_addr  = req_addr;
         a_size  = req_size;
         a_wdata = req_wdata;
      end else begin
         a_write = lat_write;
         a_addr  = lat_addr;
         a_size  = lat_size;
         a_wdata = lat_wdata;
      end
`ifdef DMEM_SUBWORD_EN
      a_unsigned = (state == S_IDLE) ? req_unsigned : lat_unsigned;
`endif
   end

   // Address decode, range/alignment checking and byte-lane selection.
   always_comb begin
      offset   = a_addr - ADDR_BASE;
      word_idx = offset[IDX_W+1:2];
      rd_word  = mem[word_idx];
`ifdef DMEM_SUBWORD_EN
      ld_byte = rd_word[{offset[1:0], 3'b000} +: 8];
      ld_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
      case (a_size)
         2'b00: begin
            size_bad = 1'b0;
            wr_mask  = 32'h0000_00FF << {offset[1:0], 3'b000};
            wr_data  = {4{a_wdata[7:0]}};
            ld_data  = a_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         end
         2'b01: begin
            size_bad = offset[0];
            wr_mask  = offset[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            wr_data  = {2{a_wdata[15:0]}};
            ld_data  = a_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         end
         2'b10: begin
            size_bad = (offset[1:0] != 2'b00);
            wr_mask  = 32'hFFFF_FFFF;
            wr_data  = a_wdata;
            ld_data  = rd_word;
         end
         default: begin
            size_bad = 1'b1;
            wr_mask  = 32'h0;
            wr_data  = a_wdata;
            ld_data  = rd_word;
         end
      endcase
`else
      size_bad = (a_size != 2'b10) || (offset[1:0] != 2'b00);
      wr_mask  = 32'hFFFF_FFFF;
      wr_data  = a_wdata;
      ld_data  = rd_word;
`endif
      acc_error = (a_addr < ADDR_BASE) || (offset >= SPAN) || size_bad;
   end

   // Handshake FSM, latency counter, request capture and response registers.
   always_ff @(negedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state     <= S_IDLE;
         count     <= 4'd0;
         rsp_rdata <= 32'd0;
         rsp_error <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= 32'd0;
         lat_size  <= 2'b00;
         lat_wdata <= 32'd0;
`ifdef DMEM_SUBWORD_EN
         lat_unsigned <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_size  <= req_size;
                  lat_wdata <= req_wdata;
`ifdef DMEM_SUBWORD_EN
                  lat_unsigned <= req_unsigned;
`endif
                  if (LATENCY == 1) begin
                     state <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                     count <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (execute) begin
            rsp_error <= acc_error;
            rsp_rdata <= (acc_error || a_write) ? 32'd0 : ld_data;
         end
      end
   end

   // Storage array: reset image, and masked lane writes for legal stores.
   always_ff @(negedge clock or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= 32'd0;
         end
         mem[0] <= 32'd100;
         mem[1] <= 32'd200;
      end else if (execute && a_write && !acc_error) begin
         mem[word_idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench for data_memory_ctrl. Two instances
// share clock and reset: index 0 has a single-edge latency, index 1 four edges.
// Subword checks follow the DMEM_SUBWORD_EN build option.
module tb_data_memory_ctrl;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clock = 1'b0;
   logic        clear_n;
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic        req_write    [2];
   logic [31:0] req_addr     [2];
   logic [1:0]  req_size     [2];
   logic        req_unsigned [2];
   logic [31:0] req_wdata    [2];
   logic        rsp_valid    [2];
   logic        rsp_ready    [2];
   logic [31:0] rsp_rdata    [2];
   logic        rsp_error    [2];

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
   } exp_t;

   exp_t exp_q[$];
   int   compare_count  = 0;
   int   mismatch_count = 0;

   always #5 clock = ~clock;

   data_memory_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(256), .LATENCY(1)) dut_lat1 (
      .clock(clock), .clear_n(clear_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
   );

   data_memory_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(256), .LATENCY(4)) dut_lat4 (
      .clock(clock), .clear_n(clear_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic check_reset_outputs(input int k);
      checkOutput("reset req_ready", 32'(req_ready[k]), 32'd1);
      checkOutput("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
      checkOutput("reset rsp_rdata", rsp_rdata[k], 32'd0);
      checkOutput("reset rsp_error", 32'(rsp_error[k]), 32'd0);
   endtask

   // Issue one access, push its expected response, then wait for the response,
   // optionally holding rsp_ready low for 'hold' edges, and compare.
   task automatic applyStimulus(input int k, input logic wr, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int hold);
      exp_t e;
      int   edges;
      e.rdata = exp_rdata;
      e.error = exp_err;
      exp_q.push_back(e);
      @(posedge clock);
      checkOutput("req_ready idle", 32'(req_ready[k]), 32'd1);
      req_valid[k]    = 1'b1;
      req_write[k]    = wr;
      req_addr[k]     = addr;
      req_size[k]     = size;
      req_unsigned[k] = uns;
      req_wdata[k]    = wdata;
      @(negedge clock);
      edges = 1;
      @(posedge clock);
      req_valid[k]    = 1'b0;
      req_write[k]    = 1'($urandom);
      req_addr[k]     = $urandom;
      req_size[k]     = 2'($urandom);
      req_unsigned[k] = 1'($urandom);
      req_wdata[k]    = $urandom;
      while (!rsp_valid[k] && edges < 20) begin
         checkOutput("req_ready busy", 32'(req_ready[k]), 32'd0);
         @(negedge clock);
         edges++;
         @(posedge clock);
      end
      checkOutput("latency edges", 32'(edges), 32'(lat_of(k)));
      checkOutput("req_ready in resp", 32'(req_ready[k]), 32'd0);
      e = exp_q.pop_front();
      checkOutput("rsp_rdata", rsp_rdata[k], e.rdata);
      checkOutput("rsp_error", 32'(rsp_error[k]), 32'(e.error));
      for (int h = 0; h < hold; h++) begin
         req_valid[k] = 1'b1;
         req_write[k] = 1'b1;
         req_addr[k]  = BASE;
         req_size[k]  = 2'b10;
         req_wdata[k] = 32'hBAD0_BAD0;
         @(negedge clock);
         @(posedge clock);
         checkOutput("hold rsp_valid", 32'(rsp_valid[k]), 32'd1);
         checkOutput("hold rsp_rdata", rsp_rdata[k], e.rdata);
         checkOutput("hold req_ready", 32'(req_ready[k]), 32'd0);
      end
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      @(negedge clock);
      @(posedge clock);
      rsp_ready[k] = 1'b0;
      checkOutput("rsp_valid cleared", 32'(rsp_valid[k]), 32'd0);
      checkOutput("req_ready restored", 32'(req_ready[k]), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         req_valid[k]    = 1'b0;
         req_write[k]    = 1'b0;
         req_addr[k]     = 32'd0;
         req_size[k]     = 2'b10;
         req_unsigned[k] = 1'b0;
         req_wdata[k]    = 32'd0;
         rsp_ready[k]    = 1'b0;
      end
      clear_n = 1'b0;
      #12;
      check_reset_outputs(0);
      check_reset_outputs(1);
      @(posedge clock);
      clear_n = 1'b1;

      // Single-edge latency: basic load and the error cases.
      applyStimulus(0, 1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'd0, 32'd200, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0002, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 0);
      applyStimulus(0, 1'b0, 32'h1000_0400, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 0);
      applyStimulus(0, 1'b0, 32'h0FFF_FFFC, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1, 0);
      applyStimulus(0, 1'b0, 32'h1000_0000, 2'b11, 1'b0, 32'd0, 32'd0, 1'b1, 0);
      applyStimulus(0, 1'b1, 32'h1000_0400, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
      applyStimulus(0, 1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'd0, 32'd100, 1'b0, 0);

      // Backpressure, with a store request offered while the response is held.
      applyStimulus(0, 1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'd0, 32'd200, 1'b0, 5);
      applyStimulus(0, 1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'd0, 32'd100, 1'b0, 0);

`ifdef DMEM_SUBWORD_EN
      applyStimulus(0, 1'b1, 32'h1000_0001, 2'b00, 1'b0, 32'h0000_0080, 32'd0, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0001, 2'b00, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0001, 2'b00, 1'b1, 32'd0, 32'h0000_0080, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0000, 2'b10, 1'b1, 32'd0, 32'h0000_8064, 1'b0, 0);
      applyStimulus(0, 1'b1, 32'h1000_0006, 2'b01, 1'b0, 32'h1234_BEEF, 32'd0, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0006, 2'b01, 1'b0, 32'd0, 32'hFFFF_BEEF, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0006, 2'b01, 1'b1, 32'd0, 32'h0000_BEEF, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'd0, 32'hBEEF_00C8, 1'b0, 0);
      applyStimulus(0, 1'b0, 32'h1000_0005, 2'b01, 1'b0, 32'd0, 32'd0, 1'b1, 0);
`else
      applyStimulus(0, 1'b0, 32'h1000_0000, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1, 0);
      applyStimulus(0, 1'b1, 32'h1000_0000, 2'b01, 1'b0, 32'h0000_FFFF, 32'd0, 1'b1, 0);
      applyStimulus(0, 1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'd0, 32'd100, 1'b0, 0);
`endif

      // Four-edge latency: store then load back.
      applyStimulus(1, 1'b1, 32'h1000_0008, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
      applyStimulus(1, 1'b0, 32'h1000_0008, 2'b10, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);

      // Reset while a store waits out its latency.
      @(posedge clock);
      req_valid[1] = 1'b1;
      req_write[1] = 1'b1;
      req_addr[1]  = BASE;
      req_size[1]  = 2'b10;
      req_wdata[1] = 32'h1234_5678;
      @(negedge clock);
      @(posedge clock);
      req_valid[1] = 1'b0;
      @(negedge clock);
      @(posedge clock);
      checkOutput("wait req_ready", 32'(req_ready[1]), 32'd0);
      clear_n = 1'b0;
      #1;
      check_reset_outputs(1);
      @(negedge clock);
      @(posedge clock);
      clear_n = 1'b1;
      applyStimulus(1, 1'b0, 32'h1000_0000, 2'b10, 1'b0, 32'd0, 32'd100, 1'b0, 0);
      applyStimulus(1, 1'b0, 32'h1000_0008, 2'b10, 1'b0, 32'd0, 32'd0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-cycle datapath's data memory.
- Adds a valid/ready request and response handshake with configurable access latency.
- Supports byte, halfword and word accesses with sign or zero extension, a configurable base address and depth, and error reporting for out-of-range or misaligned accesses.
- Sits between the datapath's load/store path and the data storage array; one access outstanding at a time.

Parameters:
- ADDR_BASE, 32'h10000000, byte address of word 0.
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..4096.
- LATENCY, 1, falling clock edges from request accept to rsp_valid; legal range 1..8.

Ports:
- clock, in, 1, all state updates on the falling edge of clock.
- clear_n, in, 1, asynchronous active-low reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, controller can accept a request.
- req_write, in, 1, 1 = store, 0 = load.
- req_addr, in, 32, byte address.
- req_size, in, 2, 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned, in, 1, loads: 1 = zero-extend, 0 = sign-extend.
- req_wdata, in, 32, store data, right-aligned.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, consumer accepts the response.
- rsp_rdata, out, 32, load result after extension; 0 for stores and errors.
- rsp_error, out, 1, access was out of range, misaligned or illegal.

Behaviour:
- Reset (clear_n low, asynchronous):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0.
  - Array cleared to 0, then word0=100 and word1=200.
- FSM IDLE:
  - req_ready=1.
  - req_valid at a falling edge latches the request (addr, size, unsigned, write, wdata).
  - If LATENCY=1, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
- FSM WAIT:
  - req_ready=0; counter decrements each edge.
  - When the counter reaches 1, the next edge goes to RESP.
- Transition into RESP: the access executes on this edge.
  - A store writes the selected byte lanes only.
  - A load samples the word and registers the extended result into rsp_rdata.
- FSM RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable until rsp_ready.
  - On rsp_ready at an edge, go to IDLE and clear rsp_valid.
  - req_ready stays 0, so there is no same-edge re-accept; minimum throughput is one access per LATENCY+1 edges.
- Addressing:
  - offset = req_addr - ADDR_BASE; word index = offset>>2, little-endian lanes.
  - Byte: lane = offset[1:0].
  - Half: lanes offset[1]*2 .. +1.
- Error conditions, any of:
  - req_addr < ADDR_BASE.
  - offset >= DEPTH_WORDS*4.
  - half access with offset[0]=1.
  - word access with offset[1:0] != 0.
  - req_size=11.
- On error: no array write, rsp_rdata=0, rsp_error=1; latency is unchanged.
- Extension:
  - Byte/half sign-extend from bit 7 or 15 unless req_unsigned=1.
  - Word accesses ignore req_unsigned.
- Reset mid-operation: an in-flight request is dropped. A store not yet executed (still in WAIT) must not modify the array, then the array is reinitialised.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- DMEM_SUBWORD_EN defined: byte and halfword accesses are supported as above.
- Not defined: only req_size=10 is legal; sizes 00 and 01 are flagged rsp_error=1 with no array write. Lane-select and extension logic is omitted, and req_unsigned is ignored.

Test Plan:
- Reset, LATENCY=1, then load word 0x10000004 -> rsp_valid exactly 1 edge after accept, rsp_rdata=200, rsp_error=0.
- LATENCY=4: store word 0xDEADBEEF to 0x10000008, then load it -> rsp_valid 4 edges after each accept, load returns 0xDEADBEEF, req_ready=0 throughout.
- DMEM_SUBWORD_EN: store byte 0x80 at 0x10000001, then load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word 0x10000000 -> 0x00008064.
- Errors: load word at 0x10000002, 0x10000400 and 0x0FFFFFFC -> rsp_error=1, rsp_rdata=0; a following store to 0x10000400 leaves the array unchanged.
- Backpressure: hold rsp_ready=0 for 5 edges -> rsp_valid and rsp_rdata held stable and req_ready=0; release -> IDLE on the next edge.
- Reset mid-op, LATENCY=4: store 0x12345678 to 0x10000000, then pulse clear_n low during WAIT -> all outputs at reset values, and a subsequent load of 0x10000000 returns 100.
